// File: rtl/lightning_scheduler_pkg.sv
// Shared game package for the lightning weapon.
//   - light_state_e : scheduler FSM state encodings (also driven onto the HUD/debug port)
//   - NUM_SLOTS     : number of on-screen lightning bolt slots
package lightning_scheduler_pkg;

  localparam int NUM_SLOTS = 3;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,  // charge available, no cooldown
    ST_COOLING  = 2'd1,  // cooldown running after a launch
    ST_DEPLETED = 2'd2,  // no charge left, waiting for recharge
    ST_HALTED   = 2'd3   // game over; left only through reset
  } light_state_e;

endpackage

// File: rtl/lightning_scheduler_lowest_free_slot.sv
// Combinational priority encoder that picks the lowest-index free slot.
//   i_busy      : per-slot busy flags
//   o_grant     : one-hot grant for the lowest free slot (all zero when none is free)
//   o_none_free : high when every slot is busy
module lowest_free_slot
  import lightning_scheduler_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] i_busy,
  output logic [NUM_SLOTS-1:0] o_grant,
  output logic                 o_none_free
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    o_grant     = '0;
    o_none_free = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!i_busy[i] && o_none_free) begin
        o_grant[i]  = 1'b1;
        o_none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lightning_scheduler.sv
// Lightning weapon scheduler: turns fire edges into one-hot slot launches,
// limited by a charge pool that refills over frames and a launch cooldown.
// Ports:
//   clk, reset             : single clock, synchronous active-high reset
//   frame_tick             : one-cycle pulse per video frame
//   shoot_n                : active-low fire level (already synchronised)
//   game_over              : freezes the scheduler (absorbing HALTED state)
//   slot_hit/slot_offscreen: per-slot pulses that free an active bolt slot
//   launch                 : one-hot, one-cycle launch pulse
//   slot_active            : per-slot busy flags
//   charges                : charges available (0..MAX_CHARGES)
//   recharge_count         : frames accumulated toward the next charge
//   restart_light          : one-cycle pulse when the pool refills to MAX_CHARGES
//   state                  : FSM state encoding
module lightning_scheduler
  import lightning_scheduler_pkg::*;
#(
  parameter int MAX_CHARGES     = 3,
  parameter int RECHARGE_FRAMES = 120,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 shoot_n,
  input  logic                 game_over,
  input  logic [NUM_SLOTS-1:0] slot_hit,
  input  logic [NUM_SLOTS-1:0] slot_offscreen,
  output logic [NUM_SLOTS-1:0] launch,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [1:0]           charges,
  output logic [7:0]           recharge_count,
  output logic                 restart_light,
  output logic [1:0]           state
);

  localparam int                CD_W    = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [1:0]        MAX_C   = 2'(MAX_CHARGES);
  localparam logic [7:0]        RC_LAST = 8'(RECHARGE_FRAMES - 1);
  localparam logic [CD_W-1:0]   CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0]   CD_ONE  = CD_W'(1);

  logic                 r_shoot_n_q;
  logic [CD_W-1:0]      r_cooldown;
  logic [7:0]           r_recharge;
  logic [1:0]           r_charges;
  logic [NUM_SLOTS-1:0] r_slot_active;
  logic [NUM_SLOTS-1:0] r_launch;
  logic                 r_restart;
  light_state_e         r_state;

  logic                 w_fire;
  logic                 w_frozen;
  logic                 w_tick;
  logic                 w_do_launch;
  logic                 w_gain;
  logic [NUM_SLOTS-1:0] w_free_grant;
  logic                 w_none_free;
  logic [CD_W-1:0]      w_cooldown_next;
  logic [7:0]           w_recharge_next;
  logic [1:0]           w_charges_next;
  logic [NUM_SLOTS-1:0] w_slot_active_next;
  logic [NUM_SLOTS-1:0] w_launch_next;
  logic                 w_restart_next;
  light_state_e         w_state_next;

  lowest_free_slot u_free (
    .i_busy      (r_slot_active),
    .o_grant     (w_free_grant),
    .o_none_free (w_none_free)
  );

  // Fire edge: the registered level was released and the live level is pressed.
  assign w_fire   = r_shoot_n_q & ~shoot_n;
  // game_over freezes in the very cycle it is seen, before HALTED is registered.
  assign w_frozen = game_over | (r_state == ST_HALTED);
  assign w_tick   = frame_tick & ~w_frozen;

  // Slot freedom comes from the registered flags only, so a slot freed this
  // cycle cannot be granted until the next one.
  assign w_do_launch = w_fire & ~w_frozen & (r_state == ST_ARMED) &
                       (r_charges != 2'd0) & (r_cooldown == '0) & ~w_none_free;

  assign w_gain = w_tick & (r_charges < MAX_C) & (r_recharge == RC_LAST);

  always_comb begin
    w_recharge_next    = r_recharge;
    w_charges_next     = r_charges;
    w_cooldown_next    = r_cooldown;
    w_launch_next      = '0;
    w_slot_active_next = r_slot_active & ~(slot_hit | slot_offscreen);
    w_state_next       = r_state;

    // Recharge counts only while the pool is not full; it stays at 0 when full.
    if (w_tick && (r_charges < MAX_C)) begin
      if (r_recharge == RC_LAST) w_recharge_next = 8'd0;
      else                       w_recharge_next = r_recharge + 8'd1;
    end

    // A launch and a recharge in the same cycle cancel out on the charge count.
    unique case ({w_do_launch, w_gain})
      2'b10:   w_charges_next = r_charges - 2'd1;
      2'b01:   w_charges_next = r_charges + 2'd1;
      default: w_charges_next = r_charges;
    endcase

    if (w_do_launch) begin
      w_cooldown_next    = CD_LOAD;
      w_launch_next      = w_free_grant;
      w_slot_active_next = w_slot_active_next | w_free_grant;
    end else if (w_tick && (r_cooldown != '0)) begin
      w_cooldown_next = r_cooldown - CD_ONE;
    end

    // States follow the next counter values, so they never lag the counters.
    if (w_frozen)                     w_state_next = ST_HALTED;
    else if (w_cooldown_next != '0)   w_state_next = ST_COOLING;
    else if (w_charges_next != 2'd0)  w_state_next = ST_ARMED;
    else                              w_state_next = ST_DEPLETED;

    w_restart_next = (w_charges_next == MAX_C) && (r_charges != MAX_C);
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shoot_n_q   <= 1'b0;
      r_cooldown    <= '0;
      r_recharge    <= 8'd0;
      r_charges     <= MAX_C;
      r_slot_active <= '0;
      r_launch      <= '0;
      r_restart     <= 1'b0;
      r_state       <= ST_ARMED;
    end else begin
      r_shoot_n_q   <= shoot_n;
      r_cooldown    <= w_cooldown_next;
      r_recharge    <= w_recharge_next;
      r_charges     <= w_charges_next;
      r_slot_active <= w_slot_active_next;
      r_launch      <= w_launch_next;
      r_restart     <= w_restart_next;
      r_state       <= w_state_next;
    end
  end

  assign launch         = r_launch;
  assign slot_active    = r_slot_active;
  assign charges        = r_charges;
  assign recharge_count = r_recharge;
  assign restart_light  = r_restart;
  assign state          = r_state;

endmodule

// File: tb/tb_lightning_scheduler.sv
// Self-checking bench for lightning_scheduler: a table of directed vectors,
// hand-written multi-cycle scenarios, and a randomized run, all shadowed by a
// cycle-level behavioural model built from plain integer counters.
module tb_lightning_scheduler;

  localparam int MAXC = 3;
  localparam int RF   = 120;
  localparam int CF   = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       shoot_n;
  logic       game_over;
  logic [2:0] slot_hit;
  logic [2:0] slot_offscreen;
  logic [2:0] launch;
  logic [2:0] slot_active;
  logic [1:0] charges;
  logic [7:0] recharge_count;
  logic       restart_light;
  logic [1:0] state;

  lightning_scheduler #(
    .MAX_CHARGES     (MAXC),
    .RECHARGE_FRAMES (RF),
    .COOLDOWN_FRAMES (CF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .shoot_n        (shoot_n),
    .game_over      (game_over),
    .slot_hit       (slot_hit),
    .slot_offscreen (slot_offscreen),
    .launch         (launch),
    .slot_active    (slot_active),
    .charges        (charges),
    .recharge_count (recharge_count),
    .restart_light  (restart_light),
    .state          (state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_restart_seen = 0;

  // Behavioural model state.
  int       m_charges, m_cool, m_rc;
  bit [2:0] m_active, m_launch;
  bit       m_restart, m_halted, m_prev_shoot;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_state();
    if (m_halted)          return 3;
    else if (m_cool > 0)   return 1;
    else if (m_charges > 0) return 0;
    else                   return 2;
  endfunction

  task automatic compare_all();
    check("launch",         launch,         m_launch);
    check("slot_active",    slot_active,    m_active);
    check("charges",        charges,        m_charges);
    check("recharge_count", recharge_count, m_rc);
    check("restart_light",  restart_light,  m_restart);
    check("state",          state,          model_state());
  endtask

  task automatic do_reset();
    reset = 1'b1; shoot_n = 1'b1; frame_tick = 1'b0; game_over = 1'b0;
    slot_hit = '0; slot_offscreen = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    m_charges = MAXC; m_cool = 0; m_rc = 0; m_active = '0; m_launch = '0;
    m_restart = 0; m_halted = 0; m_prev_shoot = 0;
    compare_all();
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic sn, input logic ft, input logic go,
                      input logic [2:0] hit, input logic [2:0] off);
    int free_idx, new_charges;
    bit fire, frozen, do_l, gain;
    shoot_n = sn; frame_tick = ft; game_over = go; slot_hit = hit; slot_offscreen = off;

    fire   = m_prev_shoot && !sn;
    frozen = m_halted || go;
    free_idx = -1;
    for (int i = 2; i >= 0; i--) if (!m_active[i]) free_idx = i;
    do_l = fire && !frozen && m_charges > 0 && m_cool == 0 && free_idx >= 0;
    gain = 0;
    if (!frozen && ft && m_charges < MAXC) begin
      if (m_rc == RF - 1) begin gain = 1; m_rc = 0; end
      else m_rc++;
    end
    new_charges = m_charges - (do_l ? 1 : 0) + (gain ? 1 : 0);
    m_restart = (new_charges == MAXC) && (m_charges < MAXC);
    m_charges = new_charges;
    if (do_l) m_cool = CF;
    else if (!frozen && ft && m_cool > 0) m_cool--;
    m_active = m_active & ~(hit | off);
    m_launch = '0;
    if (do_l) begin m_launch[free_idx] = 1'b1; m_active[free_idx] = 1'b1; end
    if (go) m_halted = 1;
    m_prev_shoot = sn;

    @(posedge clk); #1;
    compare_all();
    if (restart_light) n_restart_seen++;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
  endtask

  // Fire edge followed by a release; returns the launch seen after the edge.
  task automatic fire(output logic [2:0] seen);
    step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    seen = launch;
    idle();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
      idle();
    end
  endtask

  typedef struct {
    logic       sn, ft;
    logic [2:0] hit, off;
    logic [2:0] e_launch, e_active;
    int         e_charges, e_rc, e_state;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [2:0] seen;
    logic       cur_sn;

    // Reset, fire, launch into slot 0, hit frees it, stray pulses ignored.
    tbl[0] = '{1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 3'b001, 2, 0, 1};
    tbl[2] = '{1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b001, 2, 1, 1};
    tbl[3] = '{1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 2, 1, 1};
    tbl[4] = '{1'b1, 1'b0, 3'b000, 3'b100, 3'b000, 3'b000, 2, 1, 1};
    tbl[5] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 2, 1, 1};

    do_reset();
    check("reset_charges", charges, 3);
    check("reset_state", state, 0);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].sn, tbl[i].ft, 1'b0, tbl[i].hit, tbl[i].off);
      check("tbl_launch",  launch,         tbl[i].e_launch);
      check("tbl_active",  slot_active,    tbl[i].e_active);
      check("tbl_charges", charges,        tbl[i].e_charges);
      check("tbl_rc",      recharge_count, tbl[i].e_rc);
      check("tbl_state",   state,          tbl[i].e_state);
    end

    // Three spaced launches fill slots in order and deplete the pool.
    do_reset(); idle();
    fire(seen); check("seq3_launch0", seen, 3'b001);
    frames(11);
    fire(seen); check("seq3_launch1", seen, 3'b010);
    frames(11);
    fire(seen); check("seq3_launch2", seen, 3'b100);
    check("seq3_charges", charges, 0);
    frames(11);
    check("seq3_depleted", state, 2);
    fire(seen); check("seq3_fourth_none", seen, 3'b000);
    check("seq3_all_busy", slot_active, 3'b111);

    // All slots full with one charge regained: a hit in the fire cycle does not help.
    frames(100);
    check("full_charges", charges, 1);
    check("full_armed", state, 0);
    step(1'b0, 1'b0, 1'b0, 3'b001, 3'b000);
    check("full_no_launch", launch, 3'b000);
    check("full_slot0_free", slot_active, 3'b110);
    idle();
    fire(seen); check("full_relaunch", seen, 3'b001);
    check("full_charges_after", charges, 0);

    // Fire during cooldown is dropped.
    do_reset(); idle();
    fire(seen); check("cool_first", seen, 3'b001);
    frames(5);
    fire(seen); check("cool_dropped", seen, 3'b000);
    check("cool_charges", charges, 2);

    // Refill from two charges: exactly one restart_light pulse.
    do_reset(); idle();
    fire(seen);
    n_restart_seen = 0;
    frames(120);
    frames(3);
    check("refill_pulses", n_restart_seen, 1);
    check("refill_charges", charges, 3);
    check("refill_rc", recharge_count, 0);

    // game_over with a fire edge: no launch, halted and frozen until reset.
    do_reset(); idle();
    fire(seen);
    frames(3);
    step(1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
    check("halt_no_launch", launch, 3'b000);
    check("halt_state", state, 3);
    idle();
    frames(200);
    fire(seen); check("halt_fire_ignored", seen, 3'b000);
    check("halt_charges", charges, 2);
    check("halt_rc", recharge_count, 3);
    check("halt_state_held", state, 3);
    step(1'b1, 1'b0, 1'b0, 3'b001, 3'b000);
    check("halt_hit_frees", slot_active, 3'b000);
    do_reset();
    check("halt_reset_charges", charges, 3);
    check("halt_reset_state", state, 0);

    // Randomized run against the model, including mid-activity resets.
    do_reset();
    cur_sn = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) cur_sn = ~cur_sn;
        step(cur_sn,
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1999) == 0),
             ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
             ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lightning_scheduler.md
LIGHTNING_SCHEDULER -- requirements
Module: lightning_scheduler

Interface
REQ-001 SHALL have parameter MAX_CHARGES, default 3, maximum stored lightning charges.
REQ-002 SHALL have parameter RECHARGE_FRAMES, default 120, frames needed to regain one charge.
REQ-003 SHALL have parameter COOLDOWN_FRAMES, default 10, minimum frames between launches.
REQ-004 SHALL have port clk  in  1  system clock (clk_25 domain); the block uses one clock only.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-007 SHALL have port shoot_n  in  1  active-low fire request level, already synchronised.
REQ-008 SHALL have port game_over  in  1  level; freezes the scheduler.
REQ-009 SHALL have port slot_hit  in  3  per-slot collision pulse (bolt consumed).
REQ-010 SHALL have port slot_offscreen  in  3  per-slot pulse (bolt left screen).
REQ-011 SHALL have port launch  out  3  one-hot, one-cycle launch pulse to a lightning slot.
REQ-012 SHALL have port slot_active  out  3  per-slot busy flag.
REQ-013 SHALL have port charges  out  2  charges available, 0..MAX_CHARGES (drives light_num).
REQ-014 SHALL have port recharge_count  out  8  frames accumulated toward the next charge.
REQ-015 SHALL have port restart_light  out  1  one-cycle pulse when charges reach MAX_CHARGES.
REQ-016 SHALL have port state  out  2  FSM state encoding, for debug and HUD.

Function
REQ-017 SHALL register shoot_n once; a fire edge is defined as shoot_n_q=1 and shoot_n=0 in cycle N.
REQ-018 SHALL pulse launch in cycle N+1 only if, in cycle N: state=ARMED, charges>0, cooldown=0, and at least one slot is free.
REQ-019 SHALL drop an unserviceable fire edge; requests are not queued.
REQ-020 SHALL select the lowest-index free slot; launch is never multi-hot.
REQ-021 SHALL set slot_active[i] together with launch[i], and clear it the cycle after slot_hit[i] or slot_offscreen[i].
REQ-022 SHALL not reuse a slot that is freed in cycle N until cycle N+1.
REQ-023 SHALL ignore hit/offscreen pulses on inactive slots.
REQ-024 SHALL, on launch, decrement charges by 1 and load the cooldown counter with COOLDOWN_FRAMES.
REQ-025 SHALL decrement cooldown on each frame_tick while it is nonzero, saturating at 0.
REQ-026 SHALL, while charges<MAX_CHARGES, increment recharge_count on each frame_tick.
REQ-027 SHALL, on the frame_tick where recharge_count=RECHARGE_FRAMES-1, add one charge and clear recharge_count.
REQ-028 SHALL hold recharge_count at 0 while charges=MAX_CHARGES.
REQ-029 SHALL, when a launch and a recharge fall in the same cycle, leave charges unchanged and clear recharge_count.
REQ-030 SHALL pulse restart_light for one cycle when charges transitions to MAX_CHARGES.
REQ-031 SHALL implement a 4-state FSM:
- ARMED: cooldown=0 and charges>0.
- COOLING: cooldown>0.
- DEPLETED: cooldown=0 and charges=0.
- HALTED: entered from any state when game_over=1.
REQ-032 SHALL evaluate ARMED/COOLING/DEPLETED transitions every cycle from the next-state counter values.
REQ-033 SHALL keep HALTED as an absorbing state: exit only via reset, with no launches and no cooldown or recharge counting.
REQ-034 SHALL still honour slot_hit/slot_offscreen while HALTED.
REQ-035 SHALL take game_over=1 in the same cycle as a fire edge as priority: no launch.

Reset
REQ-036 SHALL, on reset, set charges=MAX_CHARGES, state=ARMED, and clear all of the following: cooldown, recharge_count, slot_active, launch, restart_light, shoot_n_q.
REQ-037 SHALL give reset priority over all inputs, including reset asserted mid-cooldown or while slots are active.
REQ-038 SHALL not generate a restart_light pulse from reset.

Structure
REQ-039 SHALL place the FSM state encodings and slot count (3) in the shared game package, next to the lightning drawing constants.
REQ-040 SHALL instantiate one sub-module, lowest_free_slot: a combinational 3-bit priority encoder that also outputs a none-free flag.

Verification
REQ-041 Reset, then a fire edge -> launch=001 one cycle later; charges 3->2; state=COOLING; slot_active=001.
REQ-042 Three fire edges, each spaced 11 frame_ticks apart -> launch 001, 010, 100; charges=0; state=DEPLETED; a fourth fire edge gives no launch.
REQ-043 Fire edge 5 frames after a launch (cooldown active) -> no launch; charges unchanged.
REQ-044 From charges=2, 120 frame_ticks -> charges=3; restart_light pulses exactly once; recharge_count=0.
REQ-045 slot_hit[0] and a fire edge in the same cycle with all slots full -> no launch; slot 0 free next cycle; the next fire edge launches 001.
REQ-046 game_over=1 together with a fire edge -> no launch; state=HALTED; counters frozen for 200 frames; reset restores charges=3 and state=ARMED.
